fifo_rd_packer: RTL and testbench

FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

---
 rtl/fifo_rd_packer_pkg.sv | 7 +
 rtl/pack_out_reg.sv | 33 +++
 rtl/fifo_rd_packer.sv | 89 ++++++++
 tb/tb_fifo_rd_packer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_packer_pkg.sv
// Shared types and defaults for the FIFO read-side byte packer.
package fifo_rd_packer_pkg;
  typedef enum logic {FILL = 1'b0, FLUSH = 1'b1} state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PACK   = 4;
endpackage

// File: rtl/pack_out_reg.sv
// Output holding register for packed words with a valid/ready handshake.
module pack_out_reg #(
  parameter int DATA_W = 8,
  parameter int PACK   = 4
) (
  input  logic                   rd_clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DATA_W*PACK-1:0] load_data,
  input  logic [PACK-1:0]        load_keep,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W*PACK-1:0] out_data,
  output logic [PACK-1:0]        out_keep,
  output logic                   free
);
  // Free when empty or being drained this cycle, so a new word can follow with no bubble.
  assign free = !out_valid || out_ready;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_keep  <= load_keep;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Pops DATA_W words from an async FIFO read port and packs PACK of them per output word.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PACK   = DEF_PACK
) (
  input  logic                   rd_clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_W-1:0]      fifo_dout,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W*PACK-1:0] out_data,
  output logic [PACK-1:0]        out_keep
);
  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] FULL = CW'(PACK);

  logic [1:0] rst_sync;
  logic       rst_i_n;
  state_t     state;
  logic [CW-1:0] byte_cnt, cnt_nxt;
  logic          inflight;
  logic [PACK-1:0][DATA_W-1:0] lanes, lanes_nxt, word_nxt;
  logic [PACK-1:0] keep_nxt;
  logic out_free, load;

  // Assert asynchronously, release on rd_clk.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_i_n = rst_sync[1];

  // Lane view after this cycle's capture; lanes beyond the fill count are zeroed on output.
  always_comb begin
    cnt_nxt   = byte_cnt + CW'(inflight);
    lanes_nxt = lanes;
    keep_nxt  = '0;
    word_nxt  = '0;
    for (int i = 0; i < PACK; i++) begin
      if (inflight && byte_cnt == CW'(i)) lanes_nxt[i] = fifo_dout;
      keep_nxt[i] = CW'(i) < cnt_nxt;
      word_nxt[i] = keep_nxt[i] ? lanes_nxt[i] : '0;
    end
  end

  assign load = out_free &&
                ((state == FILL  && cnt_nxt == FULL) ||
                 (state == FLUSH && cnt_nxt != '0));

  // A read is allowed at exactly PACK only when that word leaves this cycle.
  assign fifo_rd_en = rst_i_n && state == FILL && !fifo_empty &&
                      (cnt_nxt < FULL || (cnt_nxt == FULL && out_free));

  always_ff @(posedge rd_clk or negedge rst_i_n) begin
    if (!rst_i_n) begin
      state    <= FILL;
      byte_cnt <= '0;
      inflight <= 1'b0;
      lanes    <= '0;
    end else begin
      inflight <= fifo_rd_en;
      lanes    <= lanes_nxt;
      byte_cnt <= load ? '0 : cnt_nxt;
      case (state)
        FILL:    if (flush && !load) state <= FLUSH;
        FLUSH:   if (load || cnt_nxt == '0) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

  pack_out_reg #(.DATA_W(DATA_W), .PACK(PACK)) u_out (
    .rd_clk    (rd_clk),
    .rst_n     (rst_i_n),
    .load      (load),
    .load_data (word_nxt),
    .load_keep (keep_nxt),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .free      (out_free)
  );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench: FIFO and byte-stream reference model against fifo_rd_packer.
module tb_fifo_rd_packer;
  localparam int DW = 8;
  localparam int P  = 4;

  logic rd_clk = 1'b0, rst_n = 1'b0, fifo_empty = 1'b1, flush = 1'b0, out_ready = 1'b0;
  logic fifo_rd_en, out_valid;
  logic [DW-1:0]   fifo_dout = '0;
  logic [DW*P-1:0] out_data;
  logic [P-1:0]    out_keep;

  fifo_rd_packer #(.DATA_W(DW), .PACK(P)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_keep(out_keep)
  );

  always #5 rd_clk = ~rd_clk;

  int tests = 0, fails = 0;
  logic [7:0]      fq[$];
  logic [DW*P-1:0] gd[$];
  logic [P-1:0]    gk[$];
  logic            rd_pend = 1'b0;
  logic [7:0]      rd_byte = '0;
  int cnum = 0, reads = 0, streak = 0, max_streak = 0, empty_viol = 0, hold_viol = 0;
  int ov_cnt = 0, first_rd = -1, first_ov = -1;
  logic pv = 1'b0, pr = 1'b0;
  logic [DW*P-1:0] pd = '0;
  logic [P-1:0]    pk = '0;

  function automatic logic [DW*P-1:0] packw(input logic [7:0] b[$], input int s, input int n);
    logic [DW*P-1:0] w = '0;
    for (int i = 0; i < n; i++) w = w | ((DW*P)'(b[s+i]) << (DW*i));
    return w;
  endfunction

  task automatic clr();
    gd.delete(); gk.delete();
    reads = 0; streak = 0; max_streak = 0; empty_viol = 0; hold_viol = 0;
    ov_cnt = 0; first_rd = -1; first_ov = -1;
  endtask

  // One rd_clk cycle: drive inputs mid-cycle, then observe the settled DUT response.
  task automatic cyc(input logic fl, input logic rdy, input logic fe);
    @(negedge rd_clk);
    fifo_dout  = rd_pend ? rd_byte : 8'($urandom);
    flush      = fl;
    out_ready  = rdy;
    fifo_empty = fe || (fq.size() == 0);
    #1;
    if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_keep !== pk)) hold_viol++;
    if (fifo_rd_en === 1'b1 && fifo_empty) empty_viol++;
    rd_pend = (fifo_rd_en === 1'b1) && !fifo_empty;
    if (rd_pend) begin
      rd_byte = fq.pop_front();
      reads++; streak++;
      if (streak > max_streak) max_streak = streak;
      if (first_rd < 0) first_rd = cnum;
    end else streak = 0;
    if (out_valid === 1'b1) begin
      ov_cnt++;
      if (first_ov < 0) first_ov = cnum;
      if (out_ready) begin gd.push_back(out_data); gk.push_back(out_keep); end
    end
    pv = out_valid; pr = out_ready; pd = out_data; pk = out_keep;
    cnum++;
  endtask

  task automatic assert_rst();
    @(negedge rd_clk);
    rst_n = 1'b0;
    fq.delete(); rd_pend = 1'b0; pv = 1'b0;
    #1;
  endtask

  task automatic release_rst();
    repeat (2) cyc(0, 1, 0);
    @(negedge rd_clk); rst_n = 1'b1;
    repeat (5) cyc(0, 1, 0);
  endtask

  task automatic test_reset();
    fq.push_back(8'h55);
    assert_rst();
    repeat (2) @(negedge rd_clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    tests++; if (out_data !== '0) begin fails++; $display("FAIL rst_data got=%h want=0", out_data); end
    tests++; if (out_keep !== '0) begin fails++; $display("FAIL rst_keep got=%h want=0", out_keep); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rst_rd_en got=%b want=0", fifo_rd_en); end
    release_rst();
  endtask

  task automatic test_stream();
    logic [7:0] b[$];
    clr();
    for (int i = 0; i < 8; i++) begin b.push_back(8'(8'h11 + i)); fq.push_back(8'(8'h11 + i)); end
    repeat (20) cyc(0, 1, 0);
    tests++; if (gd.size() != 2) begin fails++; $display("FAIL stream_count got=%0d want=2", gd.size()); end
    for (int i = 0; i < 2 && i < gd.size(); i++) begin
      tests++;
      if (gd[i] !== packw(b, 4*i, 4) || gk[i] !== 4'hF) begin
        fails++; $display("FAIL stream_word%0d got=%h/%h want=%h/f", i, gd[i], gk[i], packw(b, 4*i, 4));
      end
    end
    tests++; if (max_streak != 8) begin fails++; $display("FAIL stream_rd_streak got=%0d want=8", max_streak); end
    tests++; if (first_ov - first_rd != P + 1) begin fails++; $display("FAIL stream_latency got=%0d want=%0d", first_ov - first_rd, P + 1); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$];
    clr();
    for (int i = 0; i < 12; i++) begin b.push_back(8'($urandom)); fq.push_back(b[i]); end
    repeat (20) cyc(0, 0, 0);
    tests++; if (reads != 8) begin fails++; $display("FAIL bp_reads_stalled got=%0d want=8", reads); end
    repeat (20) cyc(0, 1, 0);
    tests++; if (gd.size() != 3) begin fails++; $display("FAIL bp_count got=%0d want=3", gd.size()); end
    for (int i = 0; i < 3 && i < gd.size(); i++) begin
      tests++;
      if (gd[i] !== packw(b, 4*i, 4) || gk[i] !== 4'hF) begin
        fails++; $display("FAIL bp_word%0d got=%h/%h want=%h/f", i, gd[i], gk[i], packw(b, 4*i, 4));
      end
    end
    tests++; if (hold_viol != 0) begin fails++; $display("FAIL bp_hold got=%0d want=0", hold_viol); end
  endtask

  task automatic test_flush_partial();
    logic [7:0] b[$];
    clr();
    b = '{8'hA1, 8'hA2, 8'hA3};
    foreach (b[i]) fq.push_back(b[i]);
    repeat (8) cyc(0, 1, 0);
    cyc(1, 1, 0);
    repeat (6) cyc(0, 1, 0);
    tests++; if (gd.size() != 1) begin fails++; $display("FAIL flush_count got=%0d want=1", gd.size()); end
    if (gd.size() > 0) begin
      tests++; if (gd[0] !== 32'h00A3A2A1 || gk[0] !== 4'h7) begin
        fails++; $display("FAIL flush_word got=%h/%h want=00a3a2a1/7", gd[0], gk[0]);
      end
    end
    // Back in FILL: the next four bytes must form a normal full word.
    clr(); b.delete();
    for (int i = 0; i < 4; i++) begin b.push_back(8'($urandom)); fq.push_back(b[i]); end
    repeat (12) cyc(0, 1, 0);
    tests++; if (gd.size() != 1 || gd[0] !== packw(b, 0, 4) || gk[0] !== 4'hF) begin
      fails++; $display("FAIL flush_refill got_n=%0d want=%h/f", gd.size(), packw(b, 0, 4));
    end
  endtask

  task automatic test_flush_edges();
    logic [7:0] b[$];
    int n;
    clr();
    cyc(1, 1, 0);
    repeat (6) cyc(0, 1, 0);
    tests++; if (ov_cnt != 0) begin fails++; $display("FAIL flush_empty_pulses got=%0d want=0", ov_cnt); end
    clr();
    for (int i = 0; i < 4; i++) begin b.push_back(8'($urandom)); fq.push_back(b[i]); end
    n = 0;
    while (reads < 4 && n < 50) begin cyc(0, 1, 0); n++; end
    tests++; if (reads != 4) begin fails++; $display("FAIL flush_land_timeout reads=%0d want=4", reads); end
    cyc(1, 1, 0);
    repeat (8) cyc(0, 1, 0);
    tests++; if (gd.size() != 1 || ov_cnt != 1) begin fails++; $display("FAIL flush_land_count got=%0d/%0d want=1/1", gd.size(), ov_cnt); end
    if (gd.size() > 0) begin
      tests++; if (gd[0] !== packw(b, 0, 4) || gk[0] !== 4'hF) begin
        fails++; $display("FAIL flush_land_word got=%h/%h want=%h/f", gd[0], gk[0], packw(b, 0, 4));
      end
    end
  endtask

  task automatic test_empty_toggle();
    logic [7:0] b[$];
    int n;
    clr();
    for (int i = 0; i < 16; i++) begin b.push_back(8'($urandom)); fq.push_back(b[i]); end
    n = 0;
    while (gd.size() < 4 && n < 300) begin cyc(0, ($urandom % 4) != 0, n[0]); n++; end
    tests++; if (gd.size() != 4) begin fails++; $display("FAIL toggle_count got=%0d want=4", gd.size()); end
    for (int i = 0; i < 4 && i < gd.size(); i++) begin
      tests++;
      if (gd[i] !== packw(b, 4*i, 4) || gk[i] !== 4'hF) begin
        fails++; $display("FAIL toggle_word%0d got=%h/%h want=%h/f", i, gd[i], gk[i], packw(b, 4*i, 4));
      end
    end
    tests++; if (empty_viol != 0) begin fails++; $display("FAIL toggle_rd_while_empty got=%0d want=0", empty_viol); end
    tests++; if (hold_viol != 0) begin fails++; $display("FAIL toggle_hold got=%0d want=0", hold_viol); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b[$];
    clr();
    for (int i = 0; i < 6; i++) fq.push_back(8'($urandom));
    repeat (12) cyc(0, 0, 0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mrst_pre_valid got=%b want=1", out_valid); end
    assert_rst();
    tests++; if (out_valid !== 1'b0 || out_data !== '0 || out_keep !== '0 || fifo_rd_en !== 1'b0) begin
      fails++; $display("FAIL mrst_outputs got=%b/%h/%h/%b want=0/0/0/0", out_valid, out_data, out_keep, fifo_rd_en);
    end
    release_rst();
    clr();
    for (int i = 0; i < 4; i++) begin b.push_back(8'($urandom)); fq.push_back(b[i]); end
    repeat (12) cyc(0, 1, 0);
    tests++; if (gd.size() != 1 || gd[0] !== packw(b, 0, 4) || gk[0] !== 4'hF) begin
      fails++; $display("FAIL mrst_clean_word got_n=%0d want=%h/f", gd.size(), packw(b, 0, 4));
    end
  endtask

  // Random traffic: the kept lanes of all words, in order, must equal the byte stream.
  task automatic test_random();
    logic [7:0] sent[$], rx[$];
    int shape = 0, diff = 0, n = 0;
    clr();
    for (int c = 0; c < 400; c++) begin
      if (sent.size() < 60 && ($urandom % 3) != 0) begin
        sent.push_back(8'($urandom)); fq.push_back(sent[$]);
      end
      cyc(($urandom % 20) == 0, ($urandom % 4) != 0, ($urandom % 5) == 0);
    end
    while (fq.size() != 0 && n < 200) begin cyc(0, 1, 0); n++; end
    repeat (3) cyc(0, 1, 0);
    cyc(1, 1, 0);
    repeat (10) cyc(0, 1, 0);
    foreach (gd[i]) begin
      int k = 0;
      while (k < P && gk[i][k]) k++;
      if (k == 0 || gk[i] !== P'((1 << k) - 1)) shape++;
      for (int j = 0; j < P; j++) begin
        if (j < k) rx.push_back(gd[i][DW*j +: DW]);
        else if (gd[i][DW*j +: DW] !== '0) shape++;
      end
    end
    tests++; if (rx.size() != sent.size()) begin fails++; $display("FAIL rand_bytes got=%0d want=%0d", rx.size(), sent.size()); end
    for (int i = 0; i < rx.size() && i < sent.size(); i++) if (rx[i] !== sent[i]) diff++;
    tests++; if (diff != 0) begin fails++; $display("FAIL rand_order got=%0d mismatched want=0", diff); end
    tests++; if (shape != 0) begin fails++; $display("FAIL rand_keep_shape got=%0d want=0", shape); end
    tests++; if (hold_viol != 0 || empty_viol != 0) begin
      fails++; $display("FAIL rand_protocol got=%0d/%0d want=0/0", hold_viol, empty_viol);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_partial();
    test_flush_edges();
    test_empty_toggle();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
